ram_access_controller: RTL and testbench

// - Clocked front end for the level-sensitive RAM_32bit_16aline (16-bit address, 32-bit data, is_write).
// - Accepts one CPU/bus request at a time over a valid/ready handshake.
// - Sequences RAM address/data/is_write with setup/hold margins so is_write never toggles while the address moves.
// - Returns read data (and a write ack) over a valid/ready response channel.

---
 rtl/ram_access_controller.sv | 123 ++++++++++++
 tb/tb_ram_access_controller.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/ram_access_controller.sv
// Clocked valid/ready front end for the level-sensitive RAM_32bit_16aline.
// Optional write readback check is enabled by defining RAM_CTRL_READBACK_EN.
//
// state  | meaning
// IDLE   | ready for a request; RAM address/data keep their last value
// SETUP  | address/data driven, is_write low
// ACCESS | is_write driven for writes; reads sample ram_out on the last cycle
// HOLD   | is_write low again, address/data held
// VERIFY | writes only (RAM_CTRL_READBACK_EN): read back and compare
// RESP   | response presented until the consumer takes it
module ram_access_controller #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [15:0] ram_address,
  output logic [31:0] ram_in,
  output logic        ram_is_write,
  input  logic [31:0] ram_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_HOLD,
`ifdef RAM_CTRL_READBACK_EN
    S_VERIFY,
`endif
    S_RESP
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] wait_cnt;
  logic       wr_q;
  logic       accept;
  logic       cnt_done;
  logic       timed;

  assign req_ready    = reset_n && (state == S_IDLE);
  assign accept       = req_valid && req_ready;
  assign resp_valid   = (state == S_RESP);
  assign ram_is_write = (state == S_ACCESS) && wr_q;
  assign cnt_done     = (wait_cnt == LAST_CNT);
  assign timed        = (state != S_IDLE) && (state != S_RESP);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (accept) state_nxt = S_SETUP;
      S_SETUP:  if (cnt_done) state_nxt = S_ACCESS;
      S_ACCESS: if (cnt_done) state_nxt = S_HOLD;
`ifdef RAM_CTRL_READBACK_EN
      S_HOLD:   if (cnt_done) state_nxt = wr_q ? S_VERIFY : S_RESP;
      S_VERIFY: if (cnt_done) state_nxt = S_RESP;
`else
      S_HOLD:   if (cnt_done) state_nxt = S_RESP;
`endif
      S_RESP:   if (resp_ready) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      wait_cnt    <= 4'd0;
      wr_q        <= 1'b0;
      ram_address <= 16'd0;
      ram_in      <= 32'd0;
      resp_rdata  <= 32'd0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) begin
        wait_cnt <= 4'd0;
      end else if (timed) begin
        wait_cnt <= wait_cnt + 4'd1;
      end
      if (accept) begin
        wr_q        <= req_write;
        ram_address <= req_addr;
        ram_in      <= req_write ? req_wdata : 32'd0;
        resp_rdata  <= 32'd0;
      end
      if ((state == S_ACCESS) && cnt_done && !wr_q) begin
        resp_rdata <= ram_out;
      end
`ifdef RAM_CTRL_READBACK_EN
      if ((state == S_VERIFY) && cnt_done) begin
        resp_rdata <= ram_out;
      end
`endif
    end
  end

`ifdef RAM_CTRL_READBACK_EN
  // ram_in still holds the written word, so it doubles as the compare reference.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      resp_error <= 1'b0;
    end else if (accept) begin
      resp_error <= 1'b0;
    end else if ((state == S_VERIFY) && cnt_done) begin
      resp_error <= (ram_out != ram_in);
    end
  end
`else
  assign resp_error = 1'b0;
`endif

endmodule

// File: tb/tb_ram_access_controller.sv
// Directed bench for ram_access_controller with a behavioural level-sensitive RAM.
// Expectations follow RAM_CTRL_READBACK_EN when it is defined for the build.
module tb_ram_access_controller;
  localparam int W = 1;
`ifdef RAM_CTRL_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [15:0] req_addr = 16'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [15:0] ram_address;
  logic [31:0] ram_in;
  logic        ram_is_write;
  logic [31:0] ram_out;

  logic [31:0] mem [0:65535];
  bit          stuck = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  ram_access_controller #(.WAIT_CYCLES(W)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_error(resp_error),
    .ram_address(ram_address), .ram_in(ram_in),
    .ram_is_write(ram_is_write), .ram_out(ram_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (ram_is_write) mem[ram_address] <= ram_in;
  assign ram_out = stuck ? 32'd0 : mem[ram_address];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Called at a negedge with the controller idle; bp = cycles of response backpressure.
  task automatic txn(input logic wr, input logic [15:0] a, input logic [31:0] d, input int bp,
                     output logic [31:0] rdata, output logic err, output int lat,
                     output int we_cyc, output bit addr_ok);
    int guard;
    addr_ok = 1'b1; we_cyc = 0; lat = 0; rdata = 32'd0; err = 1'b0; guard = 0;
    req_write = wr; req_addr = a; req_wdata = d; req_valid = 1'b1;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("accept_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0; req_write = ~wr; req_addr = ~a; req_wdata = ~d;
    lat = 1;
    while (!resp_valid && lat < 40) begin
      if (ram_is_write) begin
        we_cyc++;
        if (ram_address !== a || ram_in !== d) addr_ok = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    check("resp_seen", {31'd0, resp_valid}, 32'd1);
    rdata = resp_rdata;
    err   = resp_error;
    for (int i = 0; i < bp; i++) begin
      req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0BAD;
      @(negedge clk);
      check("bp_valid", {31'd0, resp_valid}, 32'd1);
      check("bp_rdata", resp_rdata, rdata);
      check("bp_req_ready", {31'd0, req_ready}, 32'd0);
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    check("post_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("post_req_ready", {31'd0, req_ready}, 32'd1);
  endtask

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs [9];
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          we_cyc;
    bit          addr_ok;
    bit          seen;
    int          guard;

    vecs[0] = '{1'b1, 16'hC3BC, 32'hE5F84AB1, 32'd0};
    vecs[1] = '{1'b0, 16'hC3BC, 32'd0,        32'hE5F84AB1};
    vecs[2] = '{1'b1, 16'hB83A, 32'h5C8C6A01, 32'd0};
    vecs[3] = '{1'b0, 16'hC3BC, 32'd0,        32'hE5F84AB1};
    vecs[4] = '{1'b0, 16'hB83A, 32'd0,        32'h5C8C6A01};
    vecs[5] = '{1'b1, 16'h0000, 32'hFFFFFFFF, 32'd0};
    vecs[6] = '{1'b1, 16'hFFFF, 32'hA5A5F00F, 32'd0};
    vecs[7] = '{1'b0, 16'h0000, 32'd0,        32'hFFFFFFFF};
    vecs[8] = '{1'b0, 16'hFFFF, 32'd0,        32'hA5A5F00F};

    reset_n = 1'b0; req_valid = 1'b1; req_write = 1'b1;
    req_addr = 16'h1234; req_wdata = 32'h1;
    repeat (3) begin
      @(negedge clk);
      check("rst_req_ready", {31'd0, req_ready}, 32'd0);
      check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      check("rst_ram_is_write", {31'd0, ram_is_write}, 32'd0);
      check("rst_ram_address", {16'd0, ram_address}, 32'd0);
    end
    req_valid = 1'b0; reset_n = 1'b1;
    @(negedge clk);
    check("rel_req_ready", {31'd0, req_ready}, 32'd1);
    check("rel_resp_valid", {31'd0, resp_valid}, 32'd0);

    for (int v = 0; v < 9; v++) begin
      txn(vecs[v].wr, vecs[v].addr, vecs[v].wdata, 0, rdata, err, lat, we_cyc, addr_ok);
      check($sformatf("v%0d_rdata", v), rdata,
            vecs[v].wr ? (RB ? vecs[v].wdata : 32'd0) : vecs[v].exp_rdata);
      check($sformatf("v%0d_error", v), {31'd0, err}, 32'd0);
      check($sformatf("v%0d_latency", v), lat,
            (vecs[v].wr && RB) ? 4 * W + 1 : 3 * W + 1);
      check($sformatf("v%0d_we_cycles", v), we_cyc, vecs[v].wr ? W : 0);
      check($sformatf("v%0d_addr_stable", v), {31'd0, addr_ok}, 32'd1);
    end

    resp_ready = 1'b0;
    txn(1'b0, 16'hB83A, 32'd0, 5, rdata, err, lat, we_cyc, addr_ok);
    check("bp_read_rdata", rdata, 32'h5C8C6A01);
    check("bp_read_latency", lat, 3 * W + 1);
    txn(1'b0, 16'h0BAD, 32'd0, 0, rdata, err, lat, we_cyc, addr_ok);
    check("bp_no_stray_write", rdata, 32'd0);

    req_write = 1'b1; req_addr = 16'h2222; req_wdata = 32'hDEADBEEF; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    guard = 0;
    while (!ram_is_write && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    check("mid_in_access", {31'd0, ram_is_write}, 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    check("mid_rst_is_write", {31'd0, ram_is_write}, 32'd0);
    check("mid_rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (resp_valid) seen = 1'b1;
    end
    check("mid_no_response", {31'd0, seen}, 32'd0);
    txn(1'b0, 16'hC3BC, 32'd0, 0, rdata, err, lat, we_cyc, addr_ok);
    check("mid_next_rdata", rdata, 32'hE5F84AB1);
    check("mid_next_latency", lat, 3 * W + 1);

    stuck = 1'b1;
    txn(1'b1, 16'h0042, 32'h12345678, 0, rdata, err, lat, we_cyc, addr_ok);
    stuck = 1'b0;
    check("stuck_error", {31'd0, err}, {31'd0, RB});
    check("stuck_rdata", rdata, 32'd0);
    check("stuck_latency", lat, RB ? 4 * W + 1 : 3 * W + 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
